// File: rtl/grf_wport_arbiter.sv
// grf_wport_arbiter: arbitrates the single GRF write port between the W-stage
// writeback and late results (mult/div, slow loads). Late writes wait in a small
// in-order queue. The head drains when the port is idle, when it has waited
// AGE_LIMIT cycles, or when the queue is full. In the last two cases W stalls.
// A granted W write squashes any queued entry with the same destination.
// Optional: define GRF_WP_TRACE_EN to print the writeback trace on every write.
module grf_wport_arbiter #(
  parameter int QDEPTH    = 4,
  parameter int AGE_LIMIT = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      w_we,
  input  logic [4:0]                w_addr,
  input  logic [31:0]               w_data,
  input  logic [31:0]               w_pc,
  input  logic                      lw_valid,
  output logic                      lw_ready,
  input  logic [4:0]                lw_addr,
  input  logic [31:0]               lw_data,
  input  logic [31:0]               lw_pc,
  output logic                      grf_we,
  output logic [4:0]                grf_a3,
  output logic [31:0]               grf_data,
  output logic [31:0]               grf_pc,
  output logic                      stall_pipe,
  input  logic [4:0]                q_a1,
  input  logic [4:0]                q_a2,
  output logic                      pend_hit1,
  output logic                      pend_hit2,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int PW = $clog2(QDEPTH);
  localparam int AW = $clog2(AGE_LIMIT + 1);
  localparam logic [AW-1:0] AGE_MAX = AW'(AGE_LIMIT);

  typedef logic [PW-1:0] ptr_t;

  logic [4:0]   addr_q [QDEPTH];
  logic [31:0]  data_q [QDEPTH];
  logic [31:0]  pc_q   [QDEPTH];
  logic [QDEPTH-1:0] vld_q, vld_d;
  ptr_t         head_q, head_d, tail_q, tail_d;
  logic [PW:0]  count_q, count_d;
  logic [AW-1:0] age_q, age_d;

  logic wreq, empty, full, head_vld;
  logic grant_w, pop, enq, enq_vld;

  assign wreq     = w_we && (w_addr != 5'd0);
  assign empty    = (count_q == '0);
  assign full     = (count_q == (PW+1)'(QDEPTH));
  assign head_vld = !empty && vld_q[head_q];
  assign lw_ready = !full;
  // $0 destinations are accepted but never take a slot.
  assign enq      = lw_valid && lw_ready && (lw_addr != 5'd0);
  // An entry overtaken by the W write granted this same cycle is born dead.
  assign enq_vld  = !(grant_w && (lw_addr == w_addr));
  assign q_count  = count_q;

  // Port grant: decide who owns the GRF write port this cycle.
  always_comb begin
    grant_w    = 1'b0;
    pop        = 1'b0;
    grf_we     = 1'b0;
    grf_a3     = 5'd0;
    grf_data   = 32'd0;
    grf_pc     = 32'd0;
    if (empty) begin
      grant_w = wreq;
    end else if (!head_vld) begin
      pop     = 1'b1;
      grant_w = wreq;
    end else if (!wreq || (age_q >= AGE_MAX) || full) begin
      pop      = 1'b1;
      grf_we   = 1'b1;
      grf_a3   = addr_q[head_q];
      grf_data = data_q[head_q];
      grf_pc   = pc_q[head_q];
    end else begin
      grant_w = 1'b1;
    end
    if (grant_w) begin
      grf_we   = 1'b1;
      grf_a3   = w_addr;
      grf_data = w_data;
      grf_pc   = w_pc;
    end
    stall_pipe = wreq && !grant_w;
  end

  // Next-state for valid bits, pointers, occupancy and head age.
  always_comb begin
    vld_d   = vld_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + {{PW{1'b0}}, enq} - {{PW{1'b0}}, pop};
    age_d   = '0;
    if (grant_w) begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (addr_q[i] == w_addr) vld_d[i] = 1'b0;
      end
    end
    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + ptr_t'(1);
    end else if (head_vld) begin
      age_d = (age_q == AGE_MAX) ? age_q : age_q + AW'(1);
    end
    if (enq) begin
      vld_d[tail_q] = enq_vld;
      tail_d        = tail_q + ptr_t'(1);
    end
  end

  // Control state; reset discards the whole queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      age_q   <= '0;
    end else begin
      vld_q   <= vld_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      age_q   <= age_d;
    end
  end

  // Payload storage; contents only matter where the valid bit is set.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= lw_addr;
      data_q[tail_q] <= lw_data;
      pc_q[tail_q]   <= lw_pc;
    end
  end

  // Hazard lookup against registered valid entries only.
  always_comb begin
    pend_hit1 = 1'b0;
    pend_hit2 = 1'b0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (vld_q[i] && (addr_q[i] == q_a1) && (q_a1 != 5'd0)) pend_hit1 = 1'b1;
      if (vld_q[i] && (addr_q[i] == q_a2) && (q_a2 != 5'd0)) pend_hit2 = 1'b1;
    end
  end

`ifdef GRF_WP_TRACE_EN
  // Writeback trace.
  always @(posedge clk) begin
    if (reset && grf_we) $display("%d@%h: $%d <= %h", $time, grf_pc, grf_a3, grf_data);
  end
`else
`endif

endmodule

// File: tb/tb_grf_wport_arbiter.sv
module tb_grf_wport_arbiter;
  localparam int QD = 4;
  localparam int AL = 3;

  logic clk = 1'b0;
  logic reset;
  logic w_we, lw_valid, lw_ready, grf_we, stall_pipe, pend_hit1, pend_hit2;
  logic [4:0] w_addr, lw_addr, grf_a3, q_a1, q_a2;
  logic [31:0] w_data, w_pc, lw_data, lw_pc, grf_data, grf_pc;
  logic [2:0] q_count;

  int total = 0;
  int bad = 0;
  logic [31:0] pc_ctr = 32'h1000;
  logic [31:0] dut_rf [32];

  grf_wport_arbiter #(.QDEPTH(QD), .AGE_LIMIT(AL)) dut (
    .clk(clk), .reset(reset),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .w_pc(w_pc),
    .lw_valid(lw_valid), .lw_ready(lw_ready), .lw_addr(lw_addr),
    .lw_data(lw_data), .lw_pc(lw_pc),
    .grf_we(grf_we), .grf_a3(grf_a3), .grf_data(grf_data), .grf_pc(grf_pc),
    .stall_pipe(stall_pipe), .q_a1(q_a1), .q_a2(q_a2),
    .pend_hit1(pend_hit1), .pend_hit2(pend_hit2), .q_count(q_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of pending late writes.
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
    bit          v;
  } ent_t;
  ent_t mq[$];
  int   mage;

  bit m_wreq, m_we, m_stall, m_pop, m_grant, m_h1, m_h2;
  logic [4:0]  m_a3;
  logic [31:0] m_data, m_pc;
  ent_t ne;

  // Compare DUT against the model every cycle, then advance the model.
  always @(negedge clk) begin
    if (!reset) begin
      mq.delete();
      mage = 0;
    end
    m_wreq = w_we && (w_addr != 0);
    m_we = 0; m_stall = 0; m_pop = 0; m_grant = 0;
    m_a3 = 0; m_data = 0; m_pc = 0;
    if (mq.size() == 0) m_grant = m_wreq;
    else if (!mq[0].v) begin m_pop = 1; m_grant = m_wreq; end
    else if (!m_wreq || mage >= AL || mq.size() == QD) begin
      m_pop = 1; m_we = 1; m_stall = m_wreq;
      m_a3 = mq[0].addr; m_data = mq[0].data; m_pc = mq[0].pc;
    end else m_grant = 1;
    if (m_grant) begin m_we = 1; m_a3 = w_addr; m_data = w_data; m_pc = w_pc; end
    m_h1 = 0; m_h2 = 0;
    foreach (mq[i]) begin
      if (mq[i].v && mq[i].addr == q_a1 && q_a1 != 0) m_h1 = 1;
      if (mq[i].v && mq[i].addr == q_a2 && q_a2 != 0) m_h2 = 1;
    end

    chk("grf_we", {31'd0, grf_we}, {31'd0, m_we});
    chk("stall_pipe", {31'd0, stall_pipe}, {31'd0, m_stall});
    chk("lw_ready", {31'd0, lw_ready}, {31'd0, mq.size() < QD});
    chk("q_count", {29'd0, q_count}, mq.size());
    chk("pend_hit1", {31'd0, pend_hit1}, {31'd0, m_h1});
    chk("pend_hit2", {31'd0, pend_hit2}, {31'd0, m_h2});
    if (m_we) begin
      chk("grf_a3", {27'd0, grf_a3}, {27'd0, m_a3});
      chk("grf_data", grf_data, m_data);
      chk("grf_pc", grf_pc, m_pc);
    end
    if (grf_we) dut_rf[grf_a3] = grf_data;

    if (reset) begin
      bit full_now;
      full_now = (mq.size() == QD);
      if (m_grant) foreach (mq[i]) if (mq[i].addr == w_addr) mq[i].v = 0;
      if (m_pop) begin void'(mq.pop_front()); mage = 0; end
      else if (mq.size() > 0) mage = (mage + 1 > AL) ? AL : mage + 1;
      else mage = 0;
      if (lw_valid && !full_now && lw_addr != 0) begin
        ne.addr = lw_addr; ne.data = lw_data; ne.pc = lw_pc;
        ne.v = !(m_grant && lw_addr == w_addr);
        mq.push_back(ne);
      end
    end
  end

  task automatic drive(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                       input bit lv, input logic [4:0] la, input logic [31:0] ld);
    @(posedge clk); #1;
    w_we = we; w_addr = wa; w_data = wd; w_pc = pc_ctr;
    lw_valid = lv; lw_addr = la; lw_data = ld; lw_pc = pc_ctr + 32'd4;
    pc_ctr = pc_ctr + 32'd8;
    @(negedge clk); #1;
  endtask

  task automatic idle();
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    w_we = 0; w_addr = 0; w_data = 0; w_pc = 0;
    lw_valid = 0; lw_addr = 0; lw_data = 0; lw_pc = 0;
    q_a1 = 0; q_a2 = 0;
    for (int i = 0; i < 32; i++) dut_rf[i] = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst q_count", {29'd0, q_count}, 32'd0);
    chk("rst lw_ready", {31'd0, lw_ready}, 32'd1);
    chk("rst grf_we", {31'd0, grf_we}, 32'd0);
    @(posedge clk); #1; reset = 1'b1;

    // W write with empty queue goes straight through
    drive(1, 5'd5, 32'h1234, 0, 5'd0, 32'd0);
    chk("w5 we", {31'd0, grf_we}, 32'd1);
    chk("w5 a3", {27'd0, grf_a3}, 32'd5);
    chk("w5 data", grf_data, 32'h1234);
    chk("w5 stall", {31'd0, stall_pipe}, 32'd0);

    // Writes to $0 never issue
    drive(1, 5'd0, 32'hDEAD, 0, 5'd0, 32'd0);
    chk("w0 we", {31'd0, grf_we}, 32'd0);

    // Late write drains the cycle after enqueue
    drive(0, 5'd0, 32'd0, 1, 5'd8, 32'hAA);
    chk("lw8 no passthru", {31'd0, grf_we}, 32'd0);
    idle();
    chk("lw8 a3", {27'd0, grf_a3}, 32'd8);
    chk("lw8 data", grf_data, 32'hAA);
    chk("lw8 cnt", {29'd0, q_count}, 32'd1);
    idle();
    chk("lw8 cnt0", {29'd0, q_count}, 32'd0);

    // Late write to $0 is dropped
    drive(0, 5'd0, 32'd0, 1, 5'd0, 32'hBAD);
    idle();
    chk("lw0 cnt", {29'd0, q_count}, 32'd0);
    chk("lw0 we", {31'd0, grf_we}, 32'd0);

    // Age-forced drain: W granted 3 cycles, then drain with stall
    q_a2 = 5'd8;
    drive(0, 5'd0, 32'd0, 1, 5'd8, 32'hBB);
    for (int k = 0; k < 3; k++) begin
      drive(1, 5'd9, 32'h99, 0, 5'd0, 32'd0);
      chk("age w9 a3", {27'd0, grf_a3}, 32'd9);
      chk("age w9 stall", {31'd0, stall_pipe}, 32'd0);
      chk("age pend2", {31'd0, pend_hit2}, 32'd1);
    end
    drive(1, 5'd9, 32'h99, 0, 5'd0, 32'd0);
    chk("age drain a3", {27'd0, grf_a3}, 32'd8);
    chk("age drain data", grf_data, 32'hBB);
    chk("age drain stall", {31'd0, stall_pipe}, 32'd1);
    drive(1, 5'd9, 32'h99, 0, 5'd0, 32'd0);
    chk("age after a3", {27'd0, grf_a3}, 32'd9);
    chk("age after stall", {31'd0, stall_pipe}, 32'd0);
    q_a2 = 5'd0;

    // Squash by younger W write to same destination
    q_a1 = 5'd7;
    drive(0, 5'd0, 32'd0, 1, 5'd7, 32'h77);
    chk("sq pend before enq", {31'd0, pend_hit1}, 32'd0);
    drive(1, 5'd7, 32'h55, 0, 5'd0, 32'd0);
    chk("sq pend queued", {31'd0, pend_hit1}, 32'd1);
    chk("sq w7 data", grf_data, 32'h55);
    idle();
    chk("sq pop we", {31'd0, grf_we}, 32'd0);
    chk("sq pend after", {31'd0, pend_hit1}, 32'd0);
    idle();
    chk("sq cnt", {29'd0, q_count}, 32'd0);
    chk("sq rf7", dut_rf[7], 32'h55);
    q_a1 = 5'd0;

    // Fill the queue under continuous W traffic
    for (int k = 1; k <= 4; k++) begin
      drive(1, 5'd20, 32'h2020, 1, 5'(k), 32'(k * 16));
      chk("fill stall", {31'd0, stall_pipe}, 32'd0);
    end
    drive(1, 5'd20, 32'h2020, 1, 5'd5, 32'h50);
    chk("full ready", {31'd0, lw_ready}, 32'd0);
    chk("full stall", {31'd0, stall_pipe}, 32'd1);
    chk("full a3", {27'd0, grf_a3}, 32'd1);
    drive(1, 5'd20, 32'h2020, 1, 5'd5, 32'h50);
    chk("refill ready", {31'd0, lw_ready}, 32'd1);
    chk("refill stall", {31'd0, stall_pipe}, 32'd0);
    drive(1, 5'd20, 32'h2020, 0, 5'd0, 32'd0);
    chk("full2 stall", {31'd0, stall_pipe}, 32'd1);
    chk("full2 a3", {27'd0, grf_a3}, 32'd2);
    repeat (4) drive(1, 5'd20, 32'h2020, 0, 5'd0, 32'd0);
    repeat (6) idle();
    chk("drain cnt", {29'd0, q_count}, 32'd0);

    // Reset mid-run with two entries queued
    drive(1, 5'd21, 32'h21, 1, 5'd11, 32'h11);
    drive(1, 5'd21, 32'h21, 1, 5'd12, 32'h12);
    @(posedge clk); #1;
    reset = 1'b0; w_we = 0; lw_valid = 0;
    #1;
    chk("mid rst cnt", {29'd0, q_count}, 32'd0);
    chk("mid rst ready", {31'd0, lw_ready}, 32'd1);
    chk("mid rst we", {31'd0, grf_we}, 32'd0);
    @(posedge clk); #1; reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      idle();
      chk("post rst we", {31'd0, grf_we}, 32'd0);
    end
    chk("post rst rf11", dut_rf[11], 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
